// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operation sequencer: opcode values,
// FSM state encoding and opcode classification helpers.
package alu_seq_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_NEG  = 4'd2;
  localparam logic [3:0] OP_NOT  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_MUL  = 4'd6;
  localparam logic [3:0] OP_DIV  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_SHRA = 4'd9;
  localparam logic [3:0] OP_SHL  = 4'd10;
  localparam logic [3:0] OP_ROR  = 4'd11;
  localparam logic [3:0] OP_ROL  = 4'd12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_Y,
    S_EXEC,
    S_WB_LO,
    S_WB_HI,
    S_DONE,
    S_ERR
  } state_t;

  // Unary ops take their only operand straight from src_a, skipping Y
  function automatic logic is_unary(input logic [3:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  // MUL/DIV produce a 64-bit result written back to LO and HI
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_ROL;
  endfunction

endpackage

// File: rtl/alu_seq_onehot.sv
// 4-bit register index to NREG-wide one-hot enable vector.
// Indices at or above NREG produce an all-zero vector.
module alu_seq_onehot #(
  parameter int NREG = 16
) (
  input  logic [3:0]      idx,
  input  logic            en,
  output logic [NREG-1:0] onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_bit
      // one comparator per register select line
      assign onehot[gi] = en && (32'(idx) == gi);
    end
  endgenerate

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle control FSM sequencing one ALU operation over the shared bus:
// Y load, operand + opcode with Z capture, then write-back to a register or
// LO/HI. All outputs are decoded from registered state (Moore).
// Optional feature macro: ALU_SEQ_STATS_EN adds saturating op_count and
// illegal_count ports.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NREG          = 16,
  parameter int MULDIV_CYCLES = 1
) (
  input  logic            clock,
  input  logic            clear_n,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [3:0]      src_a,
  input  logic [3:0]      src_b,
  input  logic [3:0]      dst,
  output logic            busy,
  output logic            done,
  output logic            illegal,
  output logic [NREG-1:0] rout,
  output logic [NREG-1:0] rin,
  output logic            y_in,
  output logic            z_in,
  output logic            z_low_out,
  output logic            z_high_out,
  output logic            lo_in,
  output logic            hi_in,
  output logic [3:0]      alu_op
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]     op_count,
  output logic [7:0]      illegal_count
`endif
);

  // EXEC is held for MULDIV_CYCLES cycles; the counter counts down to zero
  localparam logic [3:0] CNT_INIT = 4'(MULDIV_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [3:0] op_reg, op_next;
  logic [3:0] src_a_reg, src_a_next;
  logic [3:0] src_b_reg, src_b_next;
  logic [3:0] dst_reg, dst_next;
  logic [3:0] cnt_reg, cnt_next;

  logic       rout_en;
  logic [3:0] rout_idx;
  logic       rin_en;

  // State and captured request registers
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_reg <= S_IDLE;
      op_reg    <= '0;
      src_a_reg <= '0;
      src_b_reg <= '0;
      dst_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      src_a_reg <= src_a_next;
      src_b_reg <= src_b_next;
      dst_reg   <= dst_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic; request fields are captured only on acceptance in IDLE
  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    src_a_next = src_a_reg;
    src_b_next = src_b_reg;
    dst_next   = dst_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          op_next    = op;
          src_a_next = src_a;
          src_b_next = src_b;
          dst_next   = dst;
          cnt_next   = CNT_INIT;
          if (!is_legal(op))
            state_next = S_ERR;
          else if (is_unary(op))
            state_next = S_EXEC;
          else
            state_next = S_LOAD_Y;
        end
      end
      S_LOAD_Y: state_next = S_EXEC;
      S_EXEC: begin
        if (is_muldiv(op_reg) && (cnt_reg != 4'd0))
          cnt_next = cnt_reg - 4'd1;
        else
          state_next = S_WB_LO;
      end
      S_WB_LO:  state_next = is_muldiv(op_reg) ? S_WB_HI : S_DONE;
      S_WB_HI:  state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      S_ERR:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Moore output decode from the registered state and captured fields
  always_comb begin
    busy       = (state_reg != S_IDLE);
    done       = 1'b0;
    illegal    = 1'b0;
    y_in       = 1'b0;
    z_in       = 1'b0;
    z_low_out  = 1'b0;
    z_high_out = 1'b0;
    lo_in      = 1'b0;
    hi_in      = 1'b0;
    alu_op     = 4'd0;
    rout_en    = 1'b0;
    rout_idx   = src_a_reg;
    rin_en     = 1'b0;
    case (state_reg)
      S_LOAD_Y: begin
        rout_en = 1'b1;
        y_in    = 1'b1;
      end
      S_EXEC: begin
        rout_en  = 1'b1;
        rout_idx = is_unary(op_reg) ? src_a_reg : src_b_reg;
        alu_op   = op_reg;
        z_in     = !is_muldiv(op_reg) || (cnt_reg == 4'd0);
      end
      S_WB_LO: begin
        z_low_out = 1'b1;
        lo_in     = is_muldiv(op_reg);
        rin_en    = !is_muldiv(op_reg);
      end
      S_WB_HI: begin
        z_high_out = 1'b1;
        hi_in      = 1'b1;
      end
      S_DONE: done = 1'b1;
      S_ERR: begin
        done    = 1'b1;
        illegal = 1'b1;
      end
      default: ;
    endcase
  end

  alu_seq_onehot #(.NREG(NREG)) u_rout_dec (
    .idx    (rout_idx),
    .en     (rout_en),
    .onehot (rout)
  );

  alu_seq_onehot #(.NREG(NREG)) u_rin_dec (
    .idx    (dst_reg),
    .en     (rin_en),
    .onehot (rin)
  );

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] op_count_reg;
  logic [7:0]  illegal_count_reg;

  // Saturating completion counters, one count per done pulse
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      op_count_reg      <= '0;
      illegal_count_reg <= '0;
    end else begin
      if ((state_reg == S_DONE) && (op_count_reg != 16'hFFFF))
        op_count_reg <= op_count_reg + 16'd1;
      if ((state_reg == S_ERR) && (illegal_count_reg != 8'hFF))
        illegal_count_reg <= illegal_count_reg + 8'd1;
    end
  end

  assign op_count      = op_count_reg;
  assign illegal_count = illegal_count_reg;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: table of requests, each expanded
// into an expected per-cycle output trace in a scoreboard queue, plus
// hand-written sequences for start-while-busy, start-in-DONE and async reset.
module tb_alu_op_sequencer;

  localparam int NREG = 16;
  localparam int MDC  = 3;
  localparam int NV   = 12;

  logic            clock = 1'b0;
  logic            clear_n = 1'b0;
  logic            start = 1'b0;
  logic [3:0]      op = '0;
  logic [3:0]      src_a = '0;
  logic [3:0]      src_b = '0;
  logic [3:0]      dst = '0;
  logic            busy, done, illegal;
  logic [NREG-1:0] rout, rin;
  logic            y_in, z_in, z_low_out, z_high_out, lo_in, hi_in;
  logic [3:0]      alu_op;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0]     op_count;
  logic [7:0]      illegal_count;
`endif

  always #5 clock = ~clock;

  alu_op_sequencer #(.NREG(NREG), .MULDIV_CYCLES(MDC)) dut (
    .clock      (clock),
    .clear_n    (clear_n),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .dst        (dst),
    .busy       (busy),
    .done       (done),
    .illegal    (illegal),
    .rout       (rout),
    .rin        (rin),
    .y_in       (y_in),
    .z_in       (z_in),
    .z_low_out  (z_low_out),
    .z_high_out (z_high_out),
    .lo_in      (lo_in),
    .hi_in      (hi_in),
    .alu_op     (alu_op)
`ifdef ALU_SEQ_STATS_EN
    ,
    .op_count      (op_count),
    .illegal_count (illegal_count)
`endif
  );

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        illegal;
    logic [15:0] rout;
    logic [15:0] rin;
    logic        y_in;
    logic        z_in;
    logic        z_low;
    logic        z_high;
    logic        lo_in;
    logic        hi_in;
    logic [3:0]  alu_op;
  } out_t;

  typedef struct {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] d;
    int         lat;
  } vec_t;

  out_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_ops = 0;
  int   exp_ill = 0;

  function automatic out_t dut_out();
    out_t g;
    g.busy    = busy;
    g.done    = done;
    g.illegal = illegal;
    g.rout    = rout;
    g.rin     = rin;
    g.y_in    = y_in;
    g.z_in    = z_in;
    g.z_low   = z_low_out;
    g.z_high  = z_high_out;
    g.lo_in   = lo_in;
    g.hi_in   = hi_in;
    g.alu_op  = alu_op;
    return g;
  endfunction

  task automatic check(input string name, input int cyc, input out_t want);
    out_t got;
    got = dut_out();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc%0d outputs got=%h want=%h", name, cyc, got, want);
    end
    total++;
    if (($countones(got.rout) > 1) || ($countones(got.rin) > 1) ||
        ((got.rout != 16'd0) && (got.z_low || got.z_high))) begin
      bad++;
      $display("FAIL %s cyc%0d bus_exclusive got rout=%h rin=%h zl=%b zh=%b want onehot/exclusive",
               name, cyc, got.rout, got.rin, got.z_low, got.z_high);
    end
  endtask

  // Expected trace from acceptance: one entry per cycle, ending with an idle cycle
  function automatic void push_expected(input vec_t v);
    out_t e;
    bit   un;
    bit   md;
    int   nexec;
    un = (v.op == 4'd2) || (v.op == 4'd3);
    md = (v.op == 4'd6) || (v.op == 4'd7);
    nexec = md ? MDC : 1;
    if (v.op > 4'd12) begin
      e = '0; e.busy = 1'b1; e.done = 1'b1; e.illegal = 1'b1;
      exp_q.push_back(e);
    end else begin
      if (!un) begin
        e = '0; e.busy = 1'b1; e.rout = 16'(1) << v.a; e.y_in = 1'b1;
        exp_q.push_back(e);
      end
      for (int k = 0; k < nexec; k++) begin
        e = '0; e.busy = 1'b1;
        e.rout = 16'(1) << (un ? v.a : v.b);
        e.alu_op = v.op;
        e.z_in = (k == nexec - 1);
        exp_q.push_back(e);
      end
      e = '0; e.busy = 1'b1; e.z_low = 1'b1;
      if (md) e.lo_in = 1'b1;
      else    e.rin = 16'(1) << v.d;
      exp_q.push_back(e);
      if (md) begin
        e = '0; e.busy = 1'b1; e.z_high = 1'b1; e.hi_in = 1'b1;
        exp_q.push_back(e);
      end
      e = '0; e.busy = 1'b1; e.done = 1'b1;
      exp_q.push_back(e);
    end
    e = '0;
    exp_q.push_back(e);
  endfunction

  // mode 0: plain; 1: extra start pulses while busy; 2: start with op 15 asserted in DONE
  task automatic run_vec(input string name, input vec_t v, input int mode);
    int   cyc;
    int   dones;
    int   lat;
    out_t e;
    @(negedge clock);
    start = 1'b1; op = v.op; src_a = v.a; src_b = v.b; dst = v.d;
    push_expected(v);
    @(negedge clock);
    start = 1'b0;
    op    = 4'($urandom_range(0, 15));
    src_a = 4'($urandom_range(0, 15));
    src_b = 4'($urandom_range(0, 15));
    dst   = 4'($urandom_range(0, 15));
    cyc = 1; dones = 0; lat = -1;
    while (exp_q.size() > 0) begin
      check(name, cyc, exp_q.pop_front());
      if (done === 1'b1) begin
        dones++;
        if (lat < 0) lat = cyc;
      end
      if (mode == 1) start = (cyc <= 2);
      if ((mode == 2) && (cyc == v.lat)) begin
        start = 1'b1;
        op = 4'd15;
      end
      @(negedge clock);
      cyc++;
    end
    total++;
    if (lat != v.lat) begin
      bad++;
      $display("FAIL %s latency got=%0d want=%0d", name, lat, v.lat);
    end
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL %s done_count got=%0d want=1", name, dones);
    end
    if (v.op > 4'd12) exp_ill++;
    else              exp_ops++;
    if (mode == 2) begin
      // start held through DONE is taken only in the following IDLE cycle
      start = 1'b0;
      e = '0; e.busy = 1'b1; e.done = 1'b1; e.illegal = 1'b1;
      check({name, "_late_start"}, cyc, e);
      exp_ill++;
      @(negedge clock);
      check({name, "_late_idle"}, cyc + 1, '0);
    end
  endtask

  task automatic run_div_reset();
    out_t e;
    @(negedge clock);
    start = 1'b1; op = 4'd7; src_a = 4'd1; src_b = 4'd2; dst = 4'd3;
    @(negedge clock);
    start = 1'b0;
    e = '0; e.busy = 1'b1; e.rout = 16'h0002; e.y_in = 1'b1;
    check("div_rst_loady", 1, e);
    @(negedge clock);
    e = '0; e.busy = 1'b1; e.rout = 16'h0004; e.alu_op = 4'd7;
    check("div_rst_exec", 2, e);
    #2 clear_n = 1'b0;
    #1 check("div_rst_async", 2, '0);
    @(negedge clock);
    clear_n = 1'b1;
    exp_ops = 0;
    exp_ill = 0;
    for (int k = 0; k < 8; k++) begin
      check("div_rst_after", k, '0);
      @(negedge clock);
    end
  endtask

  initial begin
    vec_t  vt[NV];
    string nm[NV];
    vec_t  v;
    vt[0]  = '{4'd4,  4'd2,  4'd3,  4'd5,  4};       nm[0]  = "add";
    vt[1]  = '{4'd3,  4'd7,  4'd9,  4'd7,  3};       nm[1]  = "not";
    vt[2]  = '{4'd6,  4'd1,  4'd2,  4'd8,  4 + MDC}; nm[2]  = "mul";
    vt[3]  = '{4'd14, 4'd3,  4'd4,  4'd5,  1};       nm[3]  = "ill14";
    vt[4]  = '{4'd5,  4'd4,  4'd4,  4'd4,  4};       nm[4]  = "sub_alias";
    vt[5]  = '{4'd7,  4'd9,  4'd10, 4'd0,  4 + MDC}; nm[5]  = "div";
    vt[6]  = '{4'd2,  4'd15, 4'd1,  4'd0,  3};       nm[6]  = "neg";
    vt[7]  = '{4'd10, 4'd1,  4'd6,  4'd1,  4};       nm[7]  = "shl";
    vt[8]  = '{4'd0,  4'd0,  4'd15, 4'd15, 4};       nm[8]  = "and";
    vt[9]  = '{4'd13, 4'd0,  4'd0,  4'd0,  1};       nm[9]  = "ill13";
    vt[10] = '{4'd15, 4'd6,  4'd6,  4'd6,  1};       nm[10] = "ill15";
    vt[11] = '{4'd12, 4'd11, 4'd12, 4'd13, 4};       nm[11] = "rol";

    // reset state
    @(negedge clock);
    check("reset0", 0, '0);
    @(negedge clock);
    check("reset1", 0, '0);
    clear_n = 1'b1;
    @(negedge clock);
    check("idle_after_reset", 0, '0);

    for (int i = 0; i < NV; i++) run_vec(nm[i], vt[i], 0);

    v = '{4'd4, 4'd2, 4'd3, 4'd5, 4};
    run_vec("add_start_busy", v, 1);
    v = '{4'd1, 4'd8, 4'd9, 4'd10, 4};
    run_vec("or_start_in_done", v, 2);

    run_div_reset();

    v = '{4'd8, 4'd3, 4'd2, 4'd14, 4};
    run_vec("shr_after_reset", v, 0);
    v = '{4'd6, 4'd5, 4'd5, 4'd5, 4 + MDC};
    run_vec("mul_after_reset", v, 0);

`ifdef ALU_SEQ_STATS_EN
    total++;
    if (op_count !== 16'(exp_ops)) begin
      bad++;
      $display("FAIL op_count got=%0d want=%0d", op_count, exp_ops);
    end
    total++;
    if (illegal_count !== 8'(exp_ill)) begin
      bad++;
      $display("FAIL illegal_count got=%0d want=%0d", illegal_count, exp_ill);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
